// File: rtl/snail_pkg.sv
// snail_pkg: shared types and defaults for the snail input-conditioning
// (debounce) stage and the downstream snail edge-detector stage.
package snail_pkg;

    // Default configuration for the debounce stage.
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;

    // Debounce FSM: two stable levels, each with a qualifying state toward the other.
    typedef enum logic [1:0] {
        LOW     = 2'd0,
        TO_HIGH = 2'd1,
        HIGH    = 2'd2,
        TO_LOW  = 2'd3
    } db_state_t;

    // Edge-detector FSM state, kept alongside the debounce types so both stages agree.
    typedef enum logic [1:0] {
        ED_WAIT_HIGH = 2'd0,
        ED_RISE      = 2'd1,
        ED_WAIT_LOW  = 2'd2,
        ED_FALL      = 2'd3
    } ed_state_t;

endpackage

// File: rtl/snail_sync.sv
// snail_sync: N-flop synchronizer bringing an asynchronous level into clk.
// All stages clear to 0 on reset; q is the last stage.
module snail_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic _rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] stage_reg;

    // Shift the raw level one stage per clock; stage 0 may go metastable, later stages settle.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[N-2:0], d};
        end
    end

    assign q = stage_reg[N-1];

endmodule

// File: rtl/snail_debounce.sv
// snail_debounce: synchronizes a bouncy raw input, qualifies each level
// change over STABLE_CYCLES consecutive identical samples, and produces a
// clean level (D_out) plus one-cycle rise/fall strobes.
// Optional build macro SNAIL_DEBOUNCE_GLITCH_CNT_EN adds an 8-bit saturating
// count of aborted qualifications on output glitch_cnt.
module snail_debounce
    import snail_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic       clk,
    input  logic       _rst,
    input  logic       raw_in,
    output logic       D_out,
    output logic       rise,
    output logic       fall,
`ifdef SNAIL_DEBOUNCE_GLITCH_CNT_EN
    output logic [7:0] glitch_cnt,
`endif
    output logic       busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_q;
    db_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             d_out_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic             busy_reg;

    snail_sync #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        ._rst (_rst),
        .d    (raw_in),
        .q    (sync_q)
    );

    // Debounce FSM with its stability counter and all registered outputs.
    // Any sample matching the current stable level during qualification
    // drops straight back to that level with no pulse.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_reg <= LOW;
            cnt_reg   <= '0;
            d_out_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            case (state_reg)
                LOW: begin
                    if (sync_q) begin
                        state_reg <= TO_HIGH;
                        cnt_reg   <= CNT_ONE;
                        busy_reg  <= 1'b1;
                    end else begin
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end
                end
                TO_HIGH: begin
                    if (!sync_q) begin
                        state_reg <= LOW;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= HIGH;
                        cnt_reg   <= '0;
                        d_out_reg <= 1'b1;
                        rise_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg   <= cnt_reg + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!sync_q) begin
                        state_reg <= TO_LOW;
                        cnt_reg   <= CNT_ONE;
                        busy_reg  <= 1'b1;
                    end else begin
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end
                end
                TO_LOW: begin
                    if (sync_q) begin
                        state_reg <= HIGH;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= LOW;
                        cnt_reg   <= '0;
                        d_out_reg <= 1'b0;
                        fall_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg   <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= LOW;
                    cnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SNAIL_DEBOUNCE_GLITCH_CNT_EN
    logic       abort;
    logic [7:0] glitch_cnt_reg;

    assign abort = ((state_reg == TO_HIGH) && !sync_q) ||
                   ((state_reg == TO_LOW)  &&  sync_q);

    // Saturating count of qualifications abandoned because the level bounced back.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            glitch_cnt_reg <= 8'd0;
        end else if (abort && (glitch_cnt_reg != 8'hFF)) begin
            glitch_cnt_reg <= glitch_cnt_reg + 8'd1;
        end
    end

    assign glitch_cnt = glitch_cnt_reg;
`endif

    assign D_out = d_out_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_snail_debounce.sv
// tb_snail_debounce: table-driven and randomized checks of snail_debounce
// against a run-length reference model of the debounce rules.
module tb_snail_debounce;
    import snail_pkg::*;

    localparam int S  = DEF_SYNC_STAGES;
    localparam int ST = DEF_STABLE_CYCLES;

    logic clk = 1'b0;
    logic rst_n;
    logic raw_in;
    logic D_out, rise, fall, busy;
`ifdef SNAIL_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    snail_debounce #(
        .SYNC_STAGES   (S),
        .STABLE_CYCLES (ST)
    ) dut (
        .clk        (clk),
        ._rst       (rst_n),
        .raw_in     (raw_in),
        .D_out      (D_out),
        .rise       (rise),
        .fall       (fall),
`ifdef SNAIL_DEBOUNCE_GLITCH_CNT_EN
        .glitch_cnt (glitch_cnt),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: raw samples travel through an S-deep delay line; the
    // debounced level flips after ST consecutive samples disagreeing with it.
    logic m_sync [S];
    logic m_level;
    int   m_run;
    logic m_rise, m_fall;
    int   m_glitch;

    typedef struct {
        logic raw;
        logic d;
        logic r;
        logic f;
        logic b;
    } vec_t;
    vec_t vt [24];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) m_sync[i] = 1'b0;
        m_level  = 1'b0;
        m_run    = 0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_glitch = 0;
    endtask

    task automatic model_edge();
        logic s;
        s = m_sync[S-1];
        for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = raw_in;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == ST) begin
                m_level = s;
                m_run   = 0;
                if (s) m_rise = 1'b1;
                else   m_fall = 1'b1;
            end
        end else begin
            if (m_run > 0 && m_glitch < 255) m_glitch++;
            m_run = 0;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_dout"}, {7'd0, D_out}, {7'd0, m_level});
        check({tag, "_rise"}, {7'd0, rise},  {7'd0, m_rise});
        check({tag, "_fall"}, {7'd0, fall},  {7'd0, m_fall});
        check({tag, "_busy"}, {7'd0, busy},  {7'd0, (m_run > 0)});
        check({tag, "_excl"}, {7'd0, rise & fall}, 8'd0);
`ifdef SNAIL_DEBOUNCE_GLITCH_CNT_EN
        check({tag, "_glitch"}, glitch_cnt, 8'(m_glitch));
`endif
    endtask

    // One clock transaction: drive, let the edge happen, advance model, compare.
    task automatic step(input logic r, input string tag);
        raw_in = r;
        @(posedge clk);
        model_edge();
        #1;
        $display("[TB] %s raw=%0b D_out=%0b rise=%0b fall=%0b busy=%0b", tag, r, D_out, rise, fall, busy);
        compare_model(tag);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        raw_in = 1'b0;
        #1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int rises;
        int rise_idx;
        int hold;
        logic lvl;

        rst_n  = 1'b0;
        raw_in = 1'b1;
        model_reset();

        // Reset check: raw_in high while reset asserted, outputs stay 0.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            $display("[TB] in_reset D_out=%0b rise=%0b fall=%0b busy=%0b", D_out, rise, fall, busy);
            check("rsthold_dout", {7'd0, D_out}, 8'd0);
            check("rsthold_rise", {7'd0, rise},  8'd0);
            check("rsthold_fall", {7'd0, fall},  8'd0);
            check("rsthold_busy", {7'd0, busy},  8'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        rise_idx = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, "post_rst");
            if (rise) begin rises++; rise_idx = i + 1; end
        end
        check("post_rst_rises", 8'(rises), 8'd1);
        check("post_rst_edge",  8'(rise_idx), 8'(S + ST));

        // Table-driven clean rise then clean fall.
        for (int i = 0; i < 24; i++) begin
            int n;
            if (i < 12) begin
                n = i + 1;
                vt[i] = '{raw: 1'b1, d: (n >= S + ST), r: (n == S + ST), f: 1'b0,
                          b: (n > S && n < S + ST)};
            end else begin
                n = i - 11;
                vt[i] = '{raw: 1'b0, d: !(n >= S + ST), r: 1'b0, f: (n == S + ST),
                          b: (n > S && n < S + ST)};
            end
        end
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(vt[i].raw, "table");
            check("tbl_dout", {7'd0, D_out}, {7'd0, vt[i].d});
            check("tbl_rise", {7'd0, rise},  {7'd0, vt[i].r});
            check("tbl_fall", {7'd0, fall},  {7'd0, vt[i].f});
            check("tbl_busy", {7'd0, busy},  {7'd0, vt[i].b});
        end

        // Glitch rejection: three high cycles are one short of qualifying.
        do_reset();
        rises = 0;
        for (int i = 0; i < 3; i++) begin step(1'b1, "glitch"); if (rise) rises++; end
        for (int i = 0; i < 8; i++) begin step(1'b0, "glitch"); if (rise) rises++; end
        check("glitch_rises", 8'(rises), 8'd0);
        check("glitch_dout", {7'd0, D_out}, 8'd0);
`ifdef SNAIL_DEBOUNCE_GLITCH_CNT_EN
        check("glitch_cnt1", glitch_cnt, 8'd1);
`endif

        // Bounce: 1,0,1,0,1 then held high; single rise timed from the last 0->1.
        do_reset();
        rises = 0;
        rise_idx = -1;
        for (int i = 0; i < 16; i++) begin
            step((i < 5) ? ((i % 2) == 0) : 1'b1, "bounce");
            if (rise) begin rises++; rise_idx = i; end
        end
        check("bounce_rises", 8'(rises), 8'd1);
        check("bounce_edge",  8'(rise_idx), 8'(4 + S + ST - 1));

        // Reset mid-qualification: abort at cnt=2, then resume cleanly.
        do_reset();
        for (int i = 0; i < S + 2; i++) step(1'b1, "midrst");
        check("midrst_busy_before", {7'd0, busy}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_busy_now", {7'd0, busy},  8'd0);
        check("midrst_dout_now", {7'd0, D_out}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            $display("[TB] midrst_hold D_out=%0b rise=%0b busy=%0b", D_out, rise, busy);
            check("midrst_rise", {7'd0, rise}, 8'd0);
            check("midrst_busy", {7'd0, busy}, 8'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        rise_idx = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, "midrst_resume");
            if (rise) begin rises++; rise_idx = i + 1; end
        end
        check("midrst_resume_rises", 8'(rises), 8'd1);
        check("midrst_resume_edge",  8'(rise_idx), 8'(S + ST));

        // Randomized bursts of varying length against the model.
        do_reset();
        lvl = 1'b0;
        for (int i = 0; i < 80; i++) begin
            lvl  = ~lvl;
            hold = $urandom_range(1, 8);
            for (int j = 0; j < hold; j++) step(lvl, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
